// File: rtl/pagerank_pkg.sv
// Shared definitions for the PageRank gather stage.
//   gather_state_t   : FSM encoding (IDLE, CLEAR, ACCUM, APPLY, DONE)
//   RANK_W           : width of a Q32.32 rank/contribution word
//   DAMP_Q16_DEFAULT : damping factor 0.85 in Q0.16
//   sat_add64()      : unsigned 64-bit add that clamps at 2^64-1
package pagerank_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ACCUM = 3'd2,
      APPLY = 3'd3,
      DONE  = 3'd4
   } gather_state_t;

   localparam int RANK_W           = 64;
   localparam int DAMP_Q16_DEFAULT = 55706;

   function automatic logic [RANK_W-1:0] sat_add64(input logic [RANK_W-1:0] a,
                                                  input logic [RANK_W-1:0] b);
      logic [RANK_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[RANK_W] ? {RANK_W{1'b1}} : sum[RANK_W-1:0];
   endfunction

endpackage

// File: rtl/counter32_bit.sv
// 32-bit up counter with synchronous clear.
//   clock, reset : system clock, synchronous active-high reset
//   inc          : advance by one this cycle
//   clr          : return to zero this cycle (wins over inc)
//   count        : current value
module counter32_bit (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] count
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pagerank_gather.sv
// Gather end of the PageRank scatter stream.
// Clears a per-node accumulator, sums incoming (node_id, contribution)
// beats with saturation, then on scatter_done applies damping node by node,
// new = BASE_TERM + (acc * DAMP_Q16) >> 16, and publishes the rank vector.
//   clock, reset     : clock, synchronous active-high reset
//   gather_enable    : low freezes FSM, node counter, accumulators, outputs
//   next_iteration   : leave DONE and clear for a new pass
//   in_valid/in_ready, in_node_id, in_contrib : contribution beat handshake
//   scatter_done     : level, sampled in ACCUM to start APPLY
//   rank_valid/rank_node_id/rank_value        : one pulse per node in APPLY
//   page_rank_new    : registered rank vector, node i at [64*i +: 64]
//   iteration_done   : high while in DONE
//   id_error         : sticky, an out-of-range node id was received
//   state_dbg        : current FSM state encoding
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is high only in ACCUM with gather_enable high, so
// a beat is never accepted while the block is frozen.
module pagerank_gather
   import pagerank_pkg::*;
#(
   parameter int                NODES_IN_GRAPH = 32,
   parameter int                FRAC_BITS      = 32,
   parameter int                DAMP_Q16       = DAMP_Q16_DEFAULT,
   parameter logic [RANK_W-1:0] BASE_TERM      = 64'h0000_0000_0999_999A
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             gather_enable,
   input  logic                             next_iteration,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [31:0]                      in_node_id,
   input  logic [RANK_W-1:0]                in_contrib,
   input  logic                             scatter_done,
   output logic                             rank_valid,
   output logic [31:0]                      rank_node_id,
   output logic [RANK_W-1:0]                rank_value,
   output logic [RANK_W*NODES_IN_GRAPH-1:0] page_rank_new,
   output logic                             iteration_done,
   output logic                             id_error,
   output logic [2:0]                       state_dbg
);

   localparam int          IDX_W  = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
   localparam logic [31:0] LAST_K = 32'(NODES_IN_GRAPH - 1);

   // The damping datapath treats words as Q32.32.
   if (FRAC_BITS != RANK_W / 2) begin : g_bad_format
      $error("pagerank_gather: FRAC_BITS must be 32 for Q32.32 words");
   end

   gather_state_t     state_q, state_d;
   logic [RANK_W-1:0] acc_q [NODES_IN_GRAPH];
   logic [RANK_W-1:0] prn_q [NODES_IN_GRAPH];

   logic              rank_valid_q, rank_valid_d;
   logic [31:0]       rank_node_id_q, rank_node_id_d;
   logic [RANK_W-1:0] rank_value_q, rank_value_d;
   logic              iteration_done_q, iteration_done_d;
   logic              id_error_q, id_error_d;

   logic [31:0]       k;
   logic              k_inc, k_clr, k_last;
   logic [IDX_W-1:0]  k_idx, in_idx;
   logic              beat, id_ok;
   logic              acc_we, prn_we;
   logic [IDX_W-1:0]  acc_idx;
   logic [RANK_W-1:0] acc_wdata;
   logic [79:0]       prod;
   logic [RANK_W-1:0] damped;

   counter32_bit u_k_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (k_inc),
      .clr   (k_clr),
      .count (k)
   );

   assign in_ready = gather_enable && (state_q == ACCUM);
   assign beat     = in_valid && in_ready;
   assign id_ok    = (in_node_id < 32'(NODES_IN_GRAPH));
   assign in_idx   = in_node_id[IDX_W-1:0];
   assign k_idx    = k[IDX_W-1:0];
   assign k_last   = (k == LAST_K);

   // 64x16 product kept at 80 bits so the >>16 cannot lose integer bits.
   assign prod   = {16'd0, acc_q[k_idx]} * 80'(DAMP_Q16);
   assign damped = sat_add64(BASE_TERM, 64'(prod >> 16));

   always_comb begin
      state_d        = state_q;
      k_inc          = 1'b0;
      k_clr          = 1'b0;
      acc_we         = 1'b0;
      acc_idx        = k_idx;
      acc_wdata      = '0;
      prn_we         = 1'b0;
      rank_valid_d   = 1'b0;
      rank_node_id_d = rank_node_id_q;
      rank_value_d   = rank_value_q;
      id_error_d     = id_error_q;
      if (gather_enable) begin
         case (state_q)
            IDLE: state_d = CLEAR;
            CLEAR: begin
               acc_we = 1'b1;
               k_inc  = 1'b1;
               if (k_last) begin
                  k_clr   = 1'b1;
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               // A beat arriving together with scatter_done is still summed.
               if (beat) begin
                  if (id_ok) begin
                     acc_we    = 1'b1;
                     acc_idx   = in_idx;
                     acc_wdata = sat_add64(acc_q[in_idx], in_contrib);
                  end else begin
                     id_error_d = 1'b1;
                  end
               end
               if (scatter_done) state_d = APPLY;
            end
            APPLY: begin
               prn_we         = 1'b1;
               rank_valid_d   = 1'b1;
               rank_node_id_d = k;
               rank_value_d   = damped;
               k_inc          = 1'b1;
               if (k_last) begin
                  k_clr   = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: if (next_iteration) state_d = CLEAR;
            default: state_d = IDLE;
         endcase
      end
      iteration_done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= IDLE;
         rank_valid_q     <= 1'b0;
         rank_node_id_q   <= '0;
         rank_value_q     <= '0;
         iteration_done_q <= 1'b0;
         id_error_q       <= 1'b0;
         for (int i = 0; i < NODES_IN_GRAPH; i++) begin
            acc_q[i] <= '0;
            prn_q[i] <= '0;
         end
      end else begin
         state_q          <= state_d;
         rank_valid_q     <= rank_valid_d;
         rank_node_id_q   <= rank_node_id_d;
         rank_value_q     <= rank_value_d;
         iteration_done_q <= iteration_done_d;
         id_error_q       <= id_error_d;
         if (acc_we) acc_q[acc_idx] <= acc_wdata;
         if (prn_we) prn_q[k_idx]   <= damped;
      end
   end

   for (genvar g = 0; g < NODES_IN_GRAPH; g++) begin : g_flat
      assign page_rank_new[g*RANK_W +: RANK_W] = prn_q[g];
   end

   assign rank_valid     = rank_valid_q;
   assign rank_node_id   = rank_node_id_q;
   assign rank_value     = rank_value_q;
   assign iteration_done = iteration_done_q;
   assign id_error       = id_error_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_pagerank_gather.sv
// Directed bench for pagerank_gather with N = 4.
module tb_pagerank_gather;

   localparam int          N   = 4;
   localparam logic [63:0] B   = 64'h0000_0000_0999_999A;  // BASE_TERM
   localparam logic [63:0] E   = 64'h0000_0000_E333_999A;  // acc = 1.0
   // acc = 2^64-1: (acc*0xD99A)>>16 = 0xD999_FFFF_FFFF_FFFF, + B
   localparam logic [63:0] S   = 64'hD99A_0000_0999_9999;
   localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

   logic          clock;
   logic          reset;
   logic          gather_enable;
   logic          next_iteration;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_node_id;
   logic [63:0]   in_contrib;
   logic          scatter_done;
   logic          rank_valid;
   logic [31:0]   rank_node_id;
   logic [63:0]   rank_value;
   logic [64*N-1:0] page_rank_new;
   logic          iteration_done;
   logic          id_error;
   logic [2:0]    state_dbg;

   int            total = 0;
   int            bad   = 0;
   logic [63:0]   exp_q[$];
   logic [63:0]   exp_r [N];

   pagerank_gather #(
      .NODES_IN_GRAPH (N)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .gather_enable  (gather_enable),
      .next_iteration (next_iteration),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_node_id     (in_node_id),
      .in_contrib     (in_contrib),
      .scatter_done   (scatter_done),
      .rank_valid     (rank_valid),
      .rank_node_id   (rank_node_id),
      .rank_value     (rank_value),
      .page_rank_new  (page_rank_new),
      .iteration_done (iteration_done),
      .id_error       (id_error),
      .state_dbg      (state_dbg)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // driver: wait for in_ready, present one beat (or a bare scatter_done)
   task automatic send_beat(input logic v, input logic [31:0] id,
                            input logic [63:0] val, input logic done);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clock);
         w++;
      end
      chk("ready_wait", 64'(in_ready), 64'd1);
      in_valid     = v;
      in_node_id   = id;
      in_contrib   = val;
      scatter_done = done;
      @(negedge clock);
      in_valid     = 1'b0;
      scatter_done = 1'b0;
   endtask

   task automatic next_iter();
      next_iteration = 1'b1;
      @(negedge clock);
      next_iteration = 1'b0;
   endtask

   // scoreboard: called right after the scatter_done edge; optionally
   // freezes the block for 5 cycles after drop_after pulses
   task automatic collect(input int drop_after);
      int n = 0;
      int seen = 0;
      int first = -1;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(exp_r[i]);
      while (seen < N && n < 60) begin
         if (rank_valid) begin
            if (first < 0) first = n;
            chk("rank_node_id", 64'(rank_node_id), 64'(seen));
            chk("rank_value", rank_value, exp_q.pop_front());
            seen++;
            if (seen == drop_after) begin
               gather_enable = 1'b0;
               repeat (5) begin
                  @(negedge clock);
                  n++;
                  chk("frozen_no_pulse", 64'(rank_valid), 64'd0);
               end
               gather_enable = 1'b1;
            end
         end
         if (seen < N) begin
            @(negedge clock);
            n++;
         end
      end
      chk("pulse_count", 64'(seen), 64'(N));
      chk("first_latency", 64'(first), 64'd1);
      chk("iteration_done", 64'(iteration_done), 64'd1);
      @(negedge clock);
      chk("no_extra_pulse", 64'(rank_valid), 64'd0);
      for (int i = 0; i < N; i++)
         chk($sformatf("page_rank_new[%0d]", i), page_rank_new[i*64 +: 64], exp_r[i]);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_rank_valid"}, 64'(rank_valid), 64'd0);
      chk({tag, "_rank_node_id"}, 64'(rank_node_id), 64'd0);
      chk({tag, "_rank_value"}, rank_value, 64'd0);
      chk({tag, "_iteration_done"}, 64'(iteration_done), 64'd0);
      chk({tag, "_id_error"}, 64'(id_error), 64'd0);
      for (int i = 0; i < N; i++)
         chk($sformatf("%s_prn[%0d]", tag, i), page_rank_new[i*64 +: 64], 64'd0);
   endtask

   initial begin
      reset          = 1'b1;
      gather_enable  = 1'b0;
      next_iteration = 1'b0;
      in_valid       = 1'b0;
      in_node_id     = '0;
      in_contrib     = '0;
      scatter_done   = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;
      gather_enable = 1'b1;

      // 1: one beat of 1.0 to node 2
      send_beat(1'b1, 32'd2, ONE, 1'b0);
      send_beat(1'b0, 32'd0, 64'd0, 1'b1);
      exp_r = '{B, B, E, B};
      collect(0);
      chk("no_id_error", 64'(id_error), 64'd0);

      // 2: two halves to node 1
      next_iter();
      send_beat(1'b1, 32'd1, 64'h8000_0000, 1'b0);
      send_beat(1'b1, 32'd1, 64'h8000_0000, 1'b0);
      send_beat(1'b0, 32'd0, 64'd0, 1'b1);
      exp_r = '{B, E, B, B};
      collect(0);

      // 3: out-of-range node id is dropped and flagged
      next_iter();
      send_beat(1'b1, 32'd7, ONE, 1'b0);
      chk("id_error_set", 64'(id_error), 64'd1);
      send_beat(1'b0, 32'd0, 64'd0, 1'b1);
      exp_r = '{B, B, B, B};
      collect(0);

      // 4: beat in the same cycle as scatter_done still counts
      next_iter();
      send_beat(1'b1, 32'd0, ONE, 1'b1);
      exp_r = '{E, B, B, B};
      collect(0);
      chk("id_error_sticky", 64'(id_error), 64'd1);

      // 5: saturating accumulate on node 3, freeze mid-APPLY
      next_iter();
      send_beat(1'b1, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send_beat(1'b1, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send_beat(1'b0, 32'd0, 64'd0, 1'b1);
      exp_r = '{B, B, B, S};
      collect(2);

      // 6: reset in the middle of ACCUM, then a fresh iteration
      next_iter();
      send_beat(1'b1, 32'd1, ONE, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("mid_reset");
      reset = 1'b0;
      send_beat(1'b1, 32'd2, ONE, 1'b0);
      send_beat(1'b0, 32'd0, 64'd0, 1'b1);
      exp_r = '{B, B, E, B};
      collect(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
